// File: rtl/kp_scan_ctrl.sv
// kp_scan_ctrl: 4x4 active-low matrix keypad scanner. Walks one low column at a
// time, samples synchronized rows at the end of each column window, classifies
// every full scan as NONE / ONE(code) / MULTI, debounces over whole scans and
// hands accepted codes out on a valid/ready port with a sticky overrun flag.
// Build option: define KP_AUTOREPEAT_EN to re-emit a held key every REPEAT_SCANS scans.
module kp_scan_ctrl #(
   parameter int SETTLE_CYCLES  = 4,
   parameter int DEBOUNCE_SCANS = 8,
   parameter int REPEAT_SCANS   = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] kpr,
   output logic [3:0] kpc,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       multi_key,
   output logic       overrun
);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_SCANS);

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

   // The two-flop synchronizer eats two cycles of every column window.
   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("kp_scan_ctrl: SETTLE_CYCLES must be at least 3");
   end
   if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
      $error("kp_scan_ctrl: DEBOUNCE_SCANS must be at least 1");
   end
   if (REPEAT_SCANS < 1) begin : g_bad_repeat
      $error("kp_scan_ctrl: REPEAT_SCANS must be at least 1");
   end

   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
   logic [SW-1:0] set_q, set_d;
   logic [1:0]    col_q, col_d;
   logic [3:0]    kpc_q, kpc_d;
   logic [1:0]    acc_n_q, acc_n_d;       // keys seen so far this scan, saturates at 2
   logic [3:0]    acc_code_q, acc_code_d;
   state_t        state_q, state_d;
   logic [3:0]    cand_q, cand_d;
   logic [DW-1:0] cnt_q, cnt_d, cnt_inc;  // press or release debounce count
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          multi_q, multi_d;
   logic          overrun_q, overrun_d;
   logic          sample, scan_end, scan_one, scan_multi, accept, xfer;
   logic [3:0]    pressed;
   logic [1:0]    smp_n, smp_row, tot_n;
   logic [3:0]    tot_code;
`ifdef KP_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_SCANS + 1);
   localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_SCANS);
   logic [RW-1:0] rpt_q, rpt_d, rpt_inc;
`endif

   // Column sequencing, row sampling and per-scan key accumulation
   always_comb begin
      sync1_d    = kpr;
      sync2_d    = sync1_q;
      sample     = (set_q == SET_LAST);
      scan_end   = sample && (col_q == 2'd3);
      set_d      = sample ? '0 : set_q + 1'b1;
      col_d      = sample ? col_q + 2'd1 : col_q;
      kpc_d      = ~(4'b1000 >> col_d);
      pressed    = ~sync2_q;
      smp_n      = 2'd0;
      smp_row    = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (pressed[i]) begin
            if (smp_n != 2'd2) smp_n = smp_n + 2'd1;
            smp_row = 2'(3 - i);
         end
      end
      tot_n    = acc_n_q;
      tot_code = acc_code_q;
      if (smp_n != 2'd0) begin
         tot_n    = (acc_n_q != 2'd0 || smp_n == 2'd2) ? 2'd2 : 2'd1;
         tot_code = (acc_n_q == 2'd0) ? {smp_row, col_q} : acc_code_q;
      end
      scan_one   = scan_end && (tot_n == 2'd1);
      scan_multi = scan_end && (tot_n == 2'd2);
      acc_n_d    = acc_n_q;
      acc_code_d = acc_code_q;
      if (sample) begin
         acc_n_d    = scan_end ? 2'd0 : tot_n;
         acc_code_d = scan_end ? 4'd0 : tot_code;
      end
   end

   // Debounce FSM: evaluated once per scan at the column-3 sample
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      cnt_inc = (cnt_q == DEB_MAX) ? cnt_q : cnt_q + 1'b1;
`ifdef KP_AUTOREPEAT_EN
      rpt_d   = rpt_q;
      rpt_inc = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + 1'b1;
`endif
      if (scan_end) begin
         case (state_q)
            IDLE: begin
               if (scan_one) begin
                  if (tot_code == cand_q) begin
                     cnt_d = cnt_inc;
                  end else begin
                     cand_d = tot_code;
                     cnt_d  = DW'(1);
                  end
                  if (cnt_d == DEB_MAX) begin
                     accept  = 1'b1;
                     state_d = HELD;
                     cnt_d   = '0;
`ifdef KP_AUTOREPEAT_EN
                     rpt_d   = '0;
`endif
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            HELD: begin
               // MULTI counts toward release just like an empty scan
               if (scan_one) begin
                  cnt_d = '0;
               end else if (cnt_inc == DEB_MAX) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
`ifdef KP_AUTOREPEAT_EN
               if (scan_one && tot_code == cand_q) begin
                  if (rpt_inc == RPT_MAX) begin
                     accept = 1'b1;
                     rpt_d  = '0;
                  end else begin
                     rpt_d = rpt_inc;
                  end
               end else begin
                  rpt_d = '0;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   // Output handshake: a same-edge transfer frees the slot for a new accept
   always_comb begin
      xfer        = key_valid_q & key_ready;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      multi_d     = scan_multi;
      if (xfer) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (accept) begin
         if (!key_valid_q || xfer) begin
            key_code_d  = tot_code;
            key_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // State registers, all cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= 4'b1111;
         sync2_q     <= 4'b1111;
         set_q       <= '0;
         col_q       <= 2'd0;
         kpc_q       <= 4'b0111;
         acc_n_q     <= 2'd0;
         acc_code_q  <= 4'd0;
         state_q     <= IDLE;
         cand_q      <= 4'd0;
         cnt_q       <= '0;
         key_code_q  <= 4'd0;
         key_valid_q <= 1'b0;
         multi_q     <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef KP_AUTOREPEAT_EN
         rpt_q       <= '0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         set_q       <= set_d;
         col_q       <= col_d;
         kpc_q       <= kpc_d;
         acc_n_q     <= acc_n_d;
         acc_code_q  <= acc_code_d;
         state_q     <= state_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         multi_q     <= multi_d;
         overrun_q   <= overrun_d;
`ifdef KP_AUTOREPEAT_EN
         rpt_q       <= rpt_d;
`endif
      end
   end

   assign kpc       = kpc_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign multi_key = multi_q;
   assign overrun   = overrun_q;
endmodule
